// File: rtl/display_pkg.sv
// Shared constants and helpers for the BCD counter / display scanner slice.
package display_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

    // A divider of one cycle still needs a one-bit register to stay legal.
    function automatic int div_width(input int scan_div);
        return (scan_div > 1) ? $clog2(scan_div) : 1;
    endfunction

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    // Non-decimal nibbles are forced to zero so the counter never leaves BCD space.
    function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] v);
        return (v > BCD_MAX) ? BCD_ZERO : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: up/down step with ripple carry/borrow and sanitised load.
module bcd_digit
    import display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] next_value,
    output logic               chain_out
);

    logic [DIGIT_W-1:0] value_q;

    // chain_out is the carry (up) or borrow (down) into the next digit, same cycle.
    always_comb begin
        next_value = value_q;
        chain_out  = 1'b0;
        if (load) begin
            next_value = bcd_sanitize(load_val);
        end else if (step) begin
            if (up) begin
                if (value_q == BCD_MAX) begin
                    next_value = BCD_ZERO;
                    chain_out  = 1'b1;
                end else begin
                    next_value = value_q + 4'd1;
                end
            end else begin
                if (value_q == BCD_ZERO) begin
                    next_value = BCD_MAX;
                    chain_out  = 1'b1;
                end else begin
                    next_value = value_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= next_value;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter feeding a multiplexed 7-segment decoder:
// one registered digit plus active-low anode enables per scan slot.
module bcd_scan_counter
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iCntEn,
    input  logic                      iUp,
    input  logic                      iLoad,
    input  logic [DIGIT_W*DIGITS-1:0] iLoadData,
    input  logic                      iBlankLead,
    output logic [DIGIT_W-1:0]        oData,
    output logic [DIGITS-1:0]         oSel,
    output logic [DIGIT_W*DIGITS-1:0] oCount,
    output logic                      oCarry
);

    localparam int CW = DIGIT_W * DIGITS;
    localparam int DW = div_width(SCAN_DIV);
    localparam int IW = idx_width(DIGITS);
    localparam logic [DIGITS-1:0] SEL_RST = ~DIGITS'(1);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_scan_counter: DIGITS must be in 1..8");
        end
        if (SCAN_DIV < 1) begin : g_bad_scan_div
            $error("bcd_scan_counter: SCAN_DIV must be >= 1");
        end
    endgenerate

    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [DIGITS:0]    chain;
    logic [DW-1:0]      div_q;
    logic [DW-1:0]      div_d;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      idx_d;
    logic               div_last;
    logic [DIGIT_W-1:0] data_q;
    logic [DIGITS-1:0]  sel_q;
    logic               carry_q;
    logic [DIGIT_W-1:0] slot_data;
    logic [DIGITS-1:0]  slot_sel;
    logic               slot_blank;
    logic               all_zero;

    // The count strobe enters digit 0; each digit forwards its wrap to the next.
    assign chain[0] = iCntEn;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (iClk),
                .rst_n      (iRst_n),
                .load       (iLoad),
                .load_val   (iLoadData[g*DIGIT_W +: DIGIT_W]),
                .step       (chain[g]),
                .up         (iUp),
                .value      (count_q[g*DIGIT_W +: DIGIT_W]),
                .next_value (count_d[g*DIGIT_W +: DIGIT_W]),
                .chain_out  (chain[g+1])
            );
        end
    endgenerate

    always_comb begin
        div_last = (div_q == DW'(SCAN_DIV - 1));
        div_d    = div_last ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (div_last) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Slot outputs come from next-state count and index so oData and oSel
    // land on the same edge; blanking walks down from the top digit.
    always_comb begin
        all_zero   = 1'b1;
        slot_data  = BCD_ZERO;
        slot_sel   = '1;
        slot_blank = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (count_d[k*DIGIT_W +: DIGIT_W] == BCD_ZERO);
            if (idx_d == IW'(k)) begin
                slot_data   = count_d[k*DIGIT_W +: DIGIT_W];
                slot_sel[k] = 1'b0;
                slot_blank  = iBlankLead && (k != 0) && all_zero;
            end
        end
        if (slot_blank) begin
            slot_sel = '1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            div_q   <= '0;
            idx_q   <= '0;
            data_q  <= BCD_ZERO;
            sel_q   <= SEL_RST;
            carry_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            data_q  <= slot_data;
            sel_q   <= slot_sel;
            carry_q <= chain[DIGITS];
        end
    end

    assign oData  = data_q;
    assign oSel   = sel_q;
    assign oCount = count_q;
    assign oCarry = carry_q;

endmodule
